// File: rtl/pipe_pkg.sv
// Shared pipeline register-file types and default widths.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;

  typedef logic [DATA_W_DEF-1:0] reg_data_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins on a tie.
module regfile_scoreboard_bits
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 i_set_en,
  input  logic [ADDR_W-1:0]    i_set_addr,
  input  logic                 i_clr_en,
  input  logic [ADDR_W-1:0]    i_clr_addr,
  input  logic [ADDR_W-1:0]    i_rd_addr1,
  input  logic [ADDR_W-1:0]    i_rd_addr2,
  output logic [2**ADDR_W-1:0] o_busy_vec,
  output logic                 o_busy1,
  output logic                 o_busy2
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_clr_hit1;
  logic             w_clr_hit2;

  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_set_en && (i_set_addr == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if (i_clr_en && (i_clr_addr == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // A same-cycle writeback releases the reader only when its data is bypassed.
  assign w_clr_hit1 = BYPASS && i_clr_en && (i_clr_addr == i_rd_addr1);
  assign w_clr_hit2 = BYPASS && i_clr_en && (i_clr_addr == i_rd_addr2);

  assign o_busy_vec = r_busy;
  assign o_busy1    = r_busy[i_rd_addr1] & ~w_clr_hit1;
  assign o_busy2    = r_busy[i_rd_addr2] & ~w_clr_hit2;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with optional bypass, hardwired R0 and busy scoreboard.
module regfile_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter bit          ZERO_REG   = 1'b0,
  parameter bit          BYPASS     = 1'b1,
  parameter bit          INIT_INDEX = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [ADDR_W-1:0]    Read_Reg_Num1,
  input  logic [ADDR_W-1:0]    Read_Reg_Num2,
  output logic [DATA_W-1:0]    Data1,
  output logic [DATA_W-1:0]    Data2,
  input  logic                 RegWrite,
  input  logic [ADDR_W-1:0]    Write_Reg_Num,
  input  logic [DATA_W-1:0]    Write_Data,
  input  logic                 Issue_En,
  input  logic [ADDR_W-1:0]    Issue_Reg_Num,
  output logic                 Busy1,
  output logic                 Busy2,
  output logic [2**ADDR_W-1:0] Busy_Vec
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_wr_en;
  logic              w_issue_en;

  // Hardwired R0 swallows both writes and issues.
  assign w_wr_en    = RegWrite & ~(ZERO_REG & (Write_Reg_Num == '0));
  assign w_issue_en = Issue_En & ~(ZERO_REG & (Issue_Reg_Num == '0));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_regs[i] <= INIT_INDEX ? DATA_W'(i) : DATA_W'(0);
      end
    end else if (w_wr_en) begin
      r_regs[Write_Reg_Num] <= Write_Data;
    end
  end

  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = r_regs[a];
    if (BYPASS && w_wr_en && (Write_Reg_Num == a)) begin
      d = Write_Data;
    end
    if (ZERO_REG && (a == '0)) begin
      d = '0;
    end
    return d;
  endfunction

  assign Data1 = f_read(Read_Reg_Num1);
  assign Data2 = f_read(Read_Reg_Num2);

  regfile_scoreboard_bits #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_bits (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_set_en   (w_issue_en),
    .i_set_addr (Issue_Reg_Num),
    .i_clr_en   (w_wr_en),
    .i_clr_addr (Write_Reg_Num),
    .i_rd_addr1 (Read_Reg_Num1),
    .i_rd_addr2 (Read_Reg_Num2),
    .o_busy_vec (Busy_Vec),
    .o_busy1    (Busy1),
    .o_busy2    (Busy2)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default instance (bypass, no R0) and a ZERO_REG=1/BYPASS=0 instance on shared stimulus.
module tb_regfile_scoreboard;
  import pipe_pkg::*;

  logic      clk;
  logic      rst;
  reg_addr_t rd1, rd2, wa, ia;
  reg_data_t wd;
  logic      we, ie;

  reg_data_t  d0_data1, d0_data2, d1_data1, d1_data2;
  logic       d0_busy1, d0_busy2, d1_busy1, d1_busy2;
  logic [7:0] d0_vec, d1_vec;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard dut0 (
    .Clk(clk), .Reset(rst),
    .Read_Reg_Num1(rd1), .Read_Reg_Num2(rd2),
    .Data1(d0_data1), .Data2(d0_data2),
    .RegWrite(we), .Write_Reg_Num(wa), .Write_Data(wd),
    .Issue_En(ie), .Issue_Reg_Num(ia),
    .Busy1(d0_busy1), .Busy2(d0_busy2), .Busy_Vec(d0_vec)
  );

  regfile_scoreboard #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (
    .Clk(clk), .Reset(rst),
    .Read_Reg_Num1(rd1), .Read_Reg_Num2(rd2),
    .Data1(d1_data1), .Data2(d1_data2),
    .RegWrite(we), .Write_Reg_Num(wa), .Write_Data(wd),
    .Issue_En(ie), .Issue_Reg_Num(ia),
    .Busy1(d1_busy1), .Busy2(d1_busy2), .Busy_Vec(d1_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply a new input vector just after the falling edge; it is captured at the next rising edge.
  task automatic drive(input logic w, input reg_addr_t a, input reg_data_t d,
                       input logic i, input reg_addr_t ir,
                       input reg_addr_t r1, input reg_addr_t r2);
    @(negedge clk);
    we = w; wa = a; wd = d; ie = i; ia = ir; rd1 = r1; rd2 = r2;
    #1;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ie = 1'b0; ia = '0;
    rd1 = 3'd3; rd2 = 3'd7;

    // Asynchronous reset before any rising edge has had Reset high
    #3 rst = 1'b1;
    #1;
    chk("rst_d0_data1", 32'(d0_data1), 32'h03);
    chk("rst_d0_data2", 32'(d0_data2), 32'h07);
    chk("rst_d0_vec",   32'(d0_vec),   32'h00);
    chk("rst_d1_vec",   32'(d1_vec),   32'h00);
    chk("rst_d1_data1", 32'(d1_data1), 32'h03);
    @(negedge clk);
    rst = 1'b0;

    // Write R5=A5 while reading it
    drive(1'b1, 3'd5, 8'hA5, 1'b0, 3'd0, 3'd5, 3'd3);
    chk("wr_bypass_d0",   32'(d0_data1), 32'hA5);
    chk("wr_nobypass_d1", 32'(d1_data1), 32'h05);
    chk("wr_other_d0",    32'(d0_data2), 32'h03);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd5);
    chk("wr_after_d0",  32'(d0_data1), 32'hA5);
    chk("wr_after_d1",  32'(d1_data1), 32'hA5);
    chk("wr_same_port", 32'(d0_data2), 32'hA5);

    // Issue R2, then write it back
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 3'd2);
    chk("iss_pre_vec", 32'(d0_vec), 32'h00);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd2);
    chk("iss_vec_d0",   32'(d0_vec),   32'h04);
    chk("iss_busy1_d0", 32'(d0_busy1), 32'h1);
    chk("iss_busy2_d0", 32'(d0_busy2), 32'h1);
    chk("iss_busy1_d1", 32'(d1_busy1), 32'h1);
    drive(1'b1, 3'd2, 8'h3C, 1'b0, 3'd0, 3'd2, 3'd2);
    chk("wb_busy1_d0", 32'(d0_busy1), 32'h0);
    chk("wb_data1_d0", 32'(d0_data1), 32'h3C);
    chk("wb_busy1_d1", 32'(d1_busy1), 32'h1);
    chk("wb_data1_d1", 32'(d1_data1), 32'h02);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd2);
    chk("wb_vec_d0",   32'(d0_vec),   32'h00);
    chk("wb_vec_d1",   32'(d1_vec),   32'h00);
    chk("wb_data1_d1b", 32'(d1_data1), 32'h3C);

    // Issue and write R4 together while already busy
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4, 3'd4);
    drive(1'b1, 3'd4, 8'h11, 1'b1, 3'd4, 3'd4, 3'd4);
    chk("sim_pre_vec",   32'(d0_vec),   32'h10);
    chk("sim_busy1_d0",  32'(d0_busy1), 32'h0);
    chk("sim_data1_d0",  32'(d0_data1), 32'h11);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd4);
    chk("sim_vec_d0",   32'(d0_vec),   32'h10);
    chk("sim_vec_d1",   32'(d1_vec),   32'h10);
    chk("sim_data1_d1", 32'(d1_data1), 32'h11);
    chk("sim_busy1_d0b", 32'(d0_busy1), 32'h1);

    // Issue R1 while writing back R6
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd6, 3'd1);
    drive(1'b1, 3'd6, 8'h66, 1'b1, 3'd1, 3'd6, 3'd1);
    chk("mix_pre_vec", 32'(d0_vec), 32'h50);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd1);
    chk("mix_vec_d0",   32'(d0_vec),   32'h12);
    chk("mix_data1_d0", 32'(d0_data1), 32'h66);
    chk("mix_busy2_d0", 32'(d0_busy2), 32'h1);

    // R0 write and issue: dropped by the ZERO_REG instance only
    drive(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd0, 3'd5);
    chk("r0_byp_d0", 32'(d0_data1), 32'hFF);
    chk("r0_byp_d1", 32'(d1_data1), 32'h00);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd5);
    chk("r0_data1_d1", 32'(d1_data1), 32'h00);
    chk("r0_vec_d1",   32'(d1_vec),   32'h12);
    chk("r0_data2_d1", 32'(d1_data2), 32'hA5);
    chk("r0_data1_d0", 32'(d0_data1), 32'hFF);
    chk("r0_vec_d0",   32'(d0_vec),   32'h13);

    // Reset between edges with R3 busy and a write of 0x77 pending
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd3, 3'd5);
    drive(1'b1, 3'd3, 8'h77, 1'b0, 3'd0, 3'd3, 3'd5);
    chk("mrst_pre_vec_d0", 32'(d0_vec), 32'h1B);
    chk("mrst_pre_vec_d1", 32'(d1_vec), 32'h1A);
    #2 rst = 1'b1;
    #1;
    chk("mrst_vec_d0",   32'(d0_vec),   32'h00);
    chk("mrst_vec_d1",   32'(d1_vec),   32'h00);
    chk("mrst_data1_d1", 32'(d1_data1), 32'h03);
    chk("mrst_data2_d0", 32'(d0_data2), 32'h05);
    @(negedge clk);
    rst = 1'b0; we = 1'b0; wa = '0; wd = '0;
    #1;
    chk("rel_data1_d0", 32'(d0_data1), 32'h03);
    chk("rel_data1_d1", 32'(d1_data1), 32'h03);
    chk("rel_vec_d0",   32'(d0_vec),   32'h00);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd0);
    chk("rel2_data1_d0", 32'(d0_data1), 32'h03);
    chk("rel2_data2_d0", 32'(d0_data2), 32'h00);
    chk("rel2_vec_d1",   32'(d1_vec),   32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the 8x8 processor register file.
- Provides 2 combinational read ports, 1 clocked write port, optional write-to-read bypass, and an optional hardwired-zero R0.
- Adds a per-register busy scoreboard: issue marks a destination busy, writeback clears it.
- Sits between decode (reads, busy checks, issue) and writeback in the pipelined datapath.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W (localparam, not overridable).
- ZERO_REG, 0: 1 = R0 always reads 0 and ignores writes/issues.
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching read ports.
- INIT_INDEX, 1: 1 = reset loads Reg[i] = i truncated to DATA_W; 0 = reset loads all zeros.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous reset, active-high
- Read_Reg_Num1  in  ADDR_W  read port 1 address
- Read_Reg_Num2  in  ADDR_W  read port 2 address
- Data1  out  DATA_W  read port 1 data
- Data2  out  DATA_W  read port 2 data
- RegWrite  in  1  write enable
- Write_Reg_Num  in  ADDR_W  write address
- Write_Data  in  DATA_W  write data
- Issue_En  in  1  mark Issue_Reg_Num busy
- Issue_Reg_Num  in  ADDR_W  destination of the newly issued instruction
- Busy1  out  1  busy status of Read_Reg_Num1
- Busy2  out  1  busy status of Read_Reg_Num2
- Busy_Vec  out  DEPTH  raw scoreboard bits, bit i = Reg i busy

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- While Reset=1:
  - Reg[i] = INIT_INDEX ? i[DATA_W-1:0] : 0, for all i.
  - Busy_Vec = 0.
  - Outputs follow combinationally from these values, e.g. Data1 = Read_Reg_Num1 when INIT_INDEX=1 and address < 2**DATA_W.
- Reset deassertion: first active edge is the first Clk rising edge with Reset=0. A reset mid-write or mid-issue discards that operation.
- Write: at posedge Clk, if RegWrite=1, Reg[Write_Reg_Num] <= Write_Data. Latency 1 cycle to the array. Non-blocking assignment; no combinational loop.
- Read: Data1/Data2 are combinational from address.
  - If BYPASS=1, RegWrite=1 and Write_Reg_Num==Read_Reg_NumN, then DataN = Write_Data in the same cycle.
  - If BYPASS=0, the new value is visible the cycle after the edge.
- ZERO_REG=1:
  - Reads of address 0 return 0, bypass included.
  - Writes and issues to address 0 are dropped.
  - Busy_Vec[0] is always 0.
- Scoreboard update at posedge Clk, applied per register:
  - set = Issue_En & (Issue_Reg_Num==i)
  - clr = RegWrite & (Write_Reg_Num==i)
  - next = set ? 1 : (clr ? 0 : busy[i])
  - Simultaneous issue and writeback to the same register leaves it busy (the new producer wins).
- BusyN = Busy_Vec[Read_Reg_NumN] & ~(RegWrite & Write_Reg_Num==Read_Reg_NumN).
  - A same-cycle writeback unblocks the reader, consistent with bypass.
  - If BYPASS=0, the clear term is omitted: BusyN = Busy_Vec[addr].
- Writes to a non-busy register are legal. The data updates and busy stays 0.
- Both read ports may address the same register; both return identical data and busy.
- No X propagation: all storage is reset.

Decomposition:
- Shared package pipe_pkg:
  - default DATA_W/ADDR_W constants
  - reg_addr_t and reg_data_t typedefs
- One natural sub-module: regfile_scoreboard_bits, which holds the DEPTH busy flops plus set/clear logic and the Busy1/Busy2 lookup. The data array stays in the top module.

Test Plan:
- Reset values: defaults, Reset=1 asynchronously mid-cycle; read addresses 3 and 7 -> Data1=3, Data2=7, Busy_Vec=0 immediately without a clock edge.
- Write then read: write R5=0xA5 with RegWrite=1 and Read_Reg_Num1=5 in the same cycle.
  - Data1=0xA5 in that cycle (BYPASS=1).
  - With BYPASS=0: Data1=5 in that cycle, 0xA5 in the next.
- Scoreboard: issue R2 -> Busy_Vec=0x04, Busy1=1 when reading R2.
  - Next cycle, writeback R2=0x3C -> Busy1=0 and Data1=0x3C in the writeback cycle; Busy_Vec=0x00 after the edge.
- Simultaneous events: issue R4 and write R4=0x11 in the same cycle while R4 is busy -> Reg[4]=0x11 and Busy_Vec[4] stays 1.
  - Issue R1 and write R6 in the same cycle -> bit1 set, bit6 cleared.
- ZERO_REG=1: write R0=0xFF and issue R0 -> Data1(addr 0)=0, Busy_Vec[0]=0; other registers unaffected.
- Reset mid-operation: with R3 busy and a write of 0x77 pending, assert Reset between edges -> Reg[3]=3 and Busy_Vec=0; the pending write does not land after release.
